rect_frame_loader: RTL

- Once per frame, copies the rect table (64 rects × 5 words) from shared data RAM into the GPU's rect memories.
- Converts relative sizes to absolute right/bottom coordinates on the way.
- Requests the RAM read port from the CPU/loader arbiter, pulses copy_start to the GPU, then streams words gap-free on the GPU's mem_din bus.
- Sits between data RAM, the memory arbiter, the VGA timing block (frame_start) and the gpu.

---
 rtl/rect_frame_loader.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/rect_frame_loader.sv
// Once per frame, copies the rect table from data RAM to the GPU rect memories.
// Relative width/height become absolute right/bottom on the way through.
module rect_frame_loader #(
  parameter int unsigned            RECT_COUNT       = 64,
  parameter int unsigned            RECT_COUNT_WIDTH = 6,
  parameter int unsigned            ADDR_WIDTH       = 16,
  parameter logic [ADDR_WIDTH-1:0]  RECT_BASE        = 16'h0100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  output logic                  mem_req,
  input  logic                  mem_grant,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [15:0]           mem_dout,
  output logic                  copy_start,
  output logic [15:0]           gpu_dout,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam int unsigned FIELD_WIDTH = 3;
  localparam int unsigned FIELDS      = 5;

  localparam logic [FIELD_WIDTH-1:0] F_LEFT   = 3'd0;
  localparam logic [FIELD_WIDTH-1:0] F_TOP    = 3'd1;
  localparam logic [FIELD_WIDTH-1:0] F_RIGHT  = 3'd2;
  localparam logic [FIELD_WIDTH-1:0] F_BOTTOM = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [FIELD_WIDTH-1:0]      field_idx;
  logic [RECT_COUNT_WIDTH-1:0] rect_idx;
  logic                        last_addr;
  logic                        first_addr;

  logic                  mem_req_d;
  logic                  busy_d;
  logic                  frame_done_d;
  logic                  copy_start_d;
  logic                  overrun_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;

  logic                   rd_valid;
  logic [FIELD_WIDTH-1:0] rd_field;
  logic [15:0]            x_q;
  logic [15:0]            y_q;

  assign last_addr  = (field_idx == FIELD_WIDTH'(FIELDS - 1)) &&
                      (rect_idx == RECT_COUNT_WIDTH'(RECT_COUNT - 1));
  assign first_addr = (field_idx == '0) && (rect_idx == '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (frame_start) state_next = S_REQ;
      S_REQ:    if (mem_grant)   state_next = S_STREAM;
      S_STREAM: if (last_addr)   state_next = S_DRAIN;
      S_DRAIN:  state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Next values of the registered control outputs
  always_comb begin
    mem_req_d    = (state_next == S_REQ) || (state_next == S_STREAM) ||
                   (state_next == S_DRAIN);
    busy_d       = (state_next != S_IDLE);
    frame_done_d = (state_next == S_DONE);
    copy_start_d = (state == S_STREAM) && first_addr;
    overrun_d    = overrun || (frame_start && (state != S_IDLE));
    mem_addr_d   = mem_addr;
    if ((state == S_IDLE) && frame_start)
      mem_addr_d = RECT_BASE;
    else if ((state == S_STREAM) && !last_addr)
      mem_addr_d = mem_addr + ADDR_WIDTH'(1);
  end

  // Control output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      copy_start <= 1'b0;
      overrun    <= 1'b0;
      mem_addr   <= '0;
    end else begin
      mem_req    <= mem_req_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      copy_start <= copy_start_d;
      overrun    <= overrun_d;
      mem_addr   <= mem_addr_d;
    end
  end

  // Field/rect counters track the address being issued; they wrap together
  always_ff @(posedge clk) begin
    if (reset || (state != S_STREAM)) begin
      field_idx <= '0;
      rect_idx  <= '0;
    end else if (field_idx == FIELD_WIDTH'(FIELDS - 1)) begin
      field_idx <= '0;
      rect_idx  <= rect_idx + RECT_COUNT_WIDTH'(1);
    end else begin
      field_idx <= field_idx + FIELD_WIDTH'(1);
    end
  end

  // Read-data pipeline: mem_dout lags the address by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_field <= '0;
      x_q      <= '0;
      y_q      <= '0;
      gpu_dout <= '0;
    end else begin
      rd_valid <= (state == S_STREAM);
      rd_field <= field_idx;
      if (rd_valid) begin
        case (rd_field)
          F_LEFT: begin
            gpu_dout <= mem_dout;
            x_q      <= mem_dout;
          end
          F_TOP: begin
            gpu_dout <= mem_dout;
            y_q      <= mem_dout;
          end
          F_RIGHT:  gpu_dout <= x_q + mem_dout;
          F_BOTTOM: gpu_dout <= y_q + mem_dout;
          default:  gpu_dout <= mem_dout;
        endcase
      end
    end
  end

endmodule
